// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the neuron sequencer:
//   W_DEFAULT - default signed data width
//   state_e   - sequencer FSM states
//   addr_w()  - address width for a given depth (never narrower than 1 bit)
// -----------------------------------------------------------------------------
package neuron_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    FEED    = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4,
    OUT     = 3'd5
  } state_e;

  // A depth of 1 still needs a 1-bit address so the port never collapses.
  function automatic int addr_w(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/weight_mem.sv
// -----------------------------------------------------------------------------
// weight_mem
// DEPTH x W weight store, synchronous write, combinational read.
// Contents are never cleared by reset.
// Ports:
//   clk      - clock
//   we_i     - write enable (already qualified by the caller)
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data (combinational)
// -----------------------------------------------------------------------------
module weight_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Storage write; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (we_i && (int'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read port.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/neuron_sequencer.sv
// -----------------------------------------------------------------------------
// neuron_sequencer
// Loads an N_IN-element input vector, then streams it with each neuron's
// weights into an external MAC core, captures the ReLU'd result and hands it
// out over a valid/ready port, once per neuron.
//
// Optional feature: define NEURON_SEQ_PERF_CNT_EN to build a 16-bit counter of
// delivered results on perf_cnt; otherwise perf_cnt is tied to 0.
//
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   start                       - begin a run (only honoured in IDLE)
//   in_valid/in_data/in_ready   - input vector load handshake
//   wt_we/wt_addr/wt_data       - weight write port (ignored while busy)
//   mac_weight/mac_in           - operand stream to the MAC
//   mac_forget/mac_oe/mac_reset - MAC control
//   mac_out                     - MAC result (already ReLU'd)
//   res_valid/res_ready/res_data/res_idx - result handshake
//   busy                        - high outside IDLE
//   perf_cnt                    - delivered-result count
// -----------------------------------------------------------------------------
module neuron_sequencer
  import neuron_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int N_NEURONS = 2,
  parameter int W         = W_DEFAULT,
  localparam int DEPTH    = N_IN * N_NEURONS,
  localparam int AW       = addr_w(DEPTH),
  localparam int NW       = addr_w(N_NEURONS),
  localparam int IW       = addr_w(N_IN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  input  logic          wt_we,
  input  logic [AW-1:0] wt_addr,
  input  logic [W-1:0]  wt_data,
  output logic [W-1:0]  mac_weight,
  output logic [W-1:0]  mac_in,
  output logic          mac_forget,
  output logic          mac_oe,
  output logic          mac_reset,
  input  logic [W-1:0]  mac_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output logic [NW-1:0] res_idx,
  output logic          busy,
  output logic [15:0]   perf_cnt
);

  state_e        state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          forget_q, forget_d;
  logic [W-1:0]  res_data_q, res_data_d;
  logic [NW-1:0] res_idx_q, res_idx_d;
  logic [W-1:0]  buf_q [N_IN];
  logic          buf_we_s;
  logic          active_s;
  logic [AW-1:0] raddr_s;
  logic [W-1:0]  wt_rdata_s;
  logic          res_fire_s;

  // Outputs are forced low while reset is asserted, not only after it.
  assign active_s   = ~reset;
  assign mac_reset  = reset;
  assign busy       = active_s & (state_q != IDLE);
  assign in_ready   = active_s & (state_q == LOAD);
  assign mac_oe     = active_s & (state_q == CAPTURE);
  assign res_valid  = active_s & (state_q == OUT);
  assign mac_forget = active_s & forget_q;
  assign res_data   = active_s ? res_data_q : {W{1'b0}};
  assign res_idx    = active_s ? res_idx_q : {NW{1'b0}};
  assign res_fire_s = res_valid & res_ready;

  assign raddr_s = AW'(n_q) * AW'(N_IN) + AW'(idx_q);

  weight_mem #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (AW)
  ) u_weight_mem (
    .clk     (clk),
    .we_i    (wt_we & ~busy),
    .waddr_i (wt_addr),
    .wdata_i (wt_data),
    .raddr_i (raddr_s),
    .rdata_o (wt_rdata_s)
  );

  // Operands are only non-zero while feeding; idx_q doubles as the feed step.
  always_comb begin
    mac_in     = {W{1'b0}};
    mac_weight = {W{1'b0}};
    if (active_s && (state_q == FEED)) begin
      mac_in     = buf_q[idx_q];
      mac_weight = wt_rdata_s;
    end else begin
      mac_in     = {W{1'b0}};
      mac_weight = {W{1'b0}};
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    buf_we_s   = 1'b0;
    res_data_d = res_data_q;
    res_idx_d  = res_idx_q;
    // The MAC clears its accumulator in the cycle after the first product.
    forget_d   = (state_q == FEED) && (idx_q == {IW{1'b0}});
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = {IW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (in_valid) begin
          buf_we_s = 1'b1;
          if (idx_q == IW'(N_IN - 1)) begin
            state_d = FEED;
            idx_d   = {IW{1'b0}};
            n_d     = {NW{1'b0}};
          end else begin
            idx_d = idx_q + {{(IW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = LOAD;
        end
      end
      FEED: begin
        if (idx_q == IW'(N_IN - 1)) begin
          state_d = DRAIN;
          idx_d   = {IW{1'b0}};
        end else begin
          idx_d = idx_q + {{(IW-1){1'b0}}, 1'b1};
        end
      end
      DRAIN: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d    = OUT;
        res_data_d = mac_out;
        res_idx_d  = n_q;
      end
      OUT: begin
        if (res_ready) begin
          if (n_q == NW'(N_NEURONS - 1)) begin
            state_d = IDLE;
            n_d     = {NW{1'b0}};
          end else begin
            // Input buffer is reused for the next neuron.
            state_d = FEED;
            n_d     = n_q + {{(NW-1){1'b0}}, 1'b1};
            idx_d   = {IW{1'b0}};
          end
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
        n_d     = {NW{1'b0}};
        idx_d   = {IW{1'b0}};
      end
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      n_q        <= {NW{1'b0}};
      idx_q      <= {IW{1'b0}};
      forget_q   <= 1'b0;
      res_data_q <= {W{1'b0}};
      res_idx_q  <= {NW{1'b0}};
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      forget_q   <= forget_d;
      res_data_q <= res_data_d;
      res_idx_q  <= res_idx_d;
    end
  end

  // Input buffer; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (buf_we_s && !reset) begin
      buf_q[idx_q] <= in_data;
    end
  end

`ifdef NEURON_SEQ_PERF_CNT_EN
  logic [15:0] perf_q, perf_d;

  // Delivered-result counter, wraps naturally at 16 bits.
  always_comb begin
    if (res_fire_s) begin
      perf_d = perf_q + 16'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= 16'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cnt = active_s ? perf_q : 16'd0;
`else
  logic unused_fire_s;
  assign unused_fire_s = res_fire_s;
  assign perf_cnt      = 16'd0;
`endif

endmodule

// File: doc/neuron_sequencer.md
NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

Interface
REQ-001 Parameter N_IN, default 4, number of inputs per neuron (1..16).
REQ-002 Parameter N_NEURONS, default 2, number of neurons evaluated per input vector (1..16).
REQ-003 Parameter W, default 8, data width; signed two's complement.
REQ-004 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse that begins a run; honoured only in IDLE.
REQ-007 in_valid / in_data / in_ready  in / in / out  1 / W / 1  input-vector load handshake.
REQ-008 wt_we / wt_addr / wt_data  in / in / in  1 / clog2(N_IN*N_NEURONS) / W  weight memory write port.
REQ-009 mac_weight / mac_in  out  W / W  operand stream to the MAC core.
REQ-010 mac_forget / mac_oe / mac_reset  out  1 / 1 / 1  MAC control.
REQ-011 mac_out  in  W  ReLU'd MAC result.
REQ-012 res_valid / res_ready / res_data / res_idx  out / in / out / out  1 / 1 / W / clog2(N_NEURONS)  result handshake.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 perf_cnt  out  16  delivered-result count (see Configuration).

Function
REQ-015 The FSM SHALL use states IDLE, LOAD, FEED, DRAIN, CAPTURE, OUT.
REQ-016 IDLE->LOAD on start; in_ready SHALL be 1 only in LOAD; each in_valid&in_ready beat SHALL be stored in buffer slot 0..N_IN-1 in arrival order.
REQ-017 LOAD->FEED on the edge that accepts beat N_IN-1; neuron index n SHALL be 0.
REQ-018 FEED SHALL last exactly N_IN cycles; in cycle i it SHALL drive mac_in=buf[i] and mac_weight=wmem[n*N_IN+i].
REQ-019 mac_forget SHALL be 1 exactly in the cycle after FEED cycle 0 (DRAIN when N_IN=1), else 0.
REQ-020 DRAIN (1 cycle) and CAPTURE (1 cycle) SHALL drive mac_weight=mac_in=0.
REQ-021 mac_oe SHALL be 1 only in CAPTURE; res_data<=mac_out and res_idx<=n SHALL be registered at the end of CAPTURE.
REQ-022 res_valid SHALL be 1 exactly in OUT; res_data/res_idx SHALL be held stable while res_valid&!res_ready.
REQ-023 On res_valid&res_ready: if n<N_NEURONS-1 then n<=n+1 and next state FEED (input buffer reused); else IDLE.
REQ-024 Latency: first FEED cycle F -> res_valid at cycle F+N_IN+2 when res_ready was high on every prior result.
REQ-025 Outside FEED, mac_weight and mac_in SHALL be 0.
REQ-026 Weight writes SHALL take effect only when busy=0; writes with busy=1 SHALL be ignored.
REQ-027 start while busy=1 SHALL be ignored; in_valid outside LOAD SHALL be ignored.
REQ-028 The sequencer SHALL perform no arithmetic on data; mac_out SHALL pass to res_data unmodified.

Reset
REQ-029 reset SHALL force IDLE from any state, including mid-FEED/OUT, with n=0, buffer index 0, res_valid=0, res_data=0, res_idx=0.
REQ-030 mac_reset SHALL equal reset combinationally; all other outputs SHALL be 0 during and after reset until start.
REQ-031 Weight memory and input buffer contents SHALL NOT be cleared by reset.

Configuration
REQ-032 With NEURON_SEQ_PERF_CNT_EN defined, perf_cnt SHALL increment by 1 (wrapping 16'hFFFF->0) on every res_valid&res_ready and clear on reset.
REQ-033 Without NEURON_SEQ_PERF_CNT_EN, perf_cnt SHALL be constant 0 and no counter logic SHALL be synthesised.

Structure
REQ-034 Package neuron_pkg SHALL hold W default, the FSM state enum, and the address-width helper.
REQ-035 Weight storage SHALL be sub-module weight_mem: N_IN*N_NEURONS x W, synchronous write, combinational read.

Verification (N_IN=4, N_NEURONS=2, real MAC core attached)
REQ-036 weights n0={1,1,1,1}, n1={-1,-1,-1,-1}, inputs {1,2,3,4} -> res (idx0,10) then (idx1,0).
REQ-037 Same run, cycle check -> mac_forget at F+1 only; mac_oe at F+5; res_valid at F+6.
REQ-038 res_ready low 5 cycles in OUT -> res_valid, res_data=10, res_idx=0 held; MAC operands 0 throughout.
REQ-039 reset in FEED cycle 2 -> next cycle IDLE, busy=0, res_valid=0; a new run then yields 10 again.
REQ-040 wt_we to addr 0 with 8'h7F while busy -> ignored; neuron 0 result still 10.
REQ-041 With NEURON_SEQ_PERF_CNT_EN, two full runs -> perf_cnt=4; without it perf_cnt=0.
